// File: rtl/write_reg_sync_pkg.sv
// Shared definitions for the CPU register write port: address map, FSM states
// and commit-strobe bit positions.
package write_reg_sync_pkg;

    localparam logic [1:0] ADDR_UNMAPPED = 2'b00;
    localparam logic [1:0] ADDR_REG1     = 2'b01;
    localparam logic [1:0] ADDR_REG2     = 2'b10;
    localparam logic [1:0] ADDR_REG3     = 2'b11;

    localparam int STB_REG1 = 0;
    localparam int STB_REG2 = 1;
    localparam int STB_REG3 = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOW    = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/write_reg_sync_sync2.sv
// Two-flop synchroniser for a single asynchronous bit, with selectable
// reset level so idle-high strobes do not fake an edge out of reset.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/write_reg_sync.sv
// CPU write port: synchronises we_n, rejects short lows, and commits the held
// address/data into three control registers with one-cycle strobes.
module write_reg_sync
    import write_reg_sync_pkg::*;
#(
    parameter int         MIN_LOW  = 2,
    parameter logic [7:0] REG1_RST = 8'h00,
    parameter logic [7:0] REG2_RST = 8'h00,
    parameter logic [7:0] REG3_RST = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       we_n,
    input  logic       cs_n,
    input  logic [1:0] addr,
    input  logic [7:0] din,
    input  logic       err_clr,
    output logic [7:0] reg1,
    output logic [7:0] reg2,
    output logic [7:0] reg3,
    output logic [2:0] wr_stb,
    output logic       wr_err,
    output logic       busy
);

    localparam logic [2:0] CNT_MAX = 3'(MIN_LOW);

    logic       we_s;
    state_t     state_q;
    logic [2:0] low_cnt_q;
    logic       h_cs_q;
    logic [1:0] h_addr_q;
    logic [7:0] h_din_q;
    logic [7:0] reg1_q, reg2_q, reg3_q;
    logic [2:0] wr_stb_q;
    logic       wr_err_q;
    logic       busy_q;

    sync2 #(.RST_VAL(1'b1)) u_we_sync (
        .clk (clk),
        .rst (rst),
        .d   (we_n),
        .q   (we_s)
    );

    // cs_n/addr/din are not synchronised: the CPU holds them stable for the
    // whole low phase plus three clocks, so sampling them while in LOW is safe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            low_cnt_q <= 3'd0;
            h_cs_q    <= 1'b0;
            h_addr_q  <= 2'b00;
            h_din_q   <= 8'h00;
            reg1_q    <= REG1_RST;
            reg2_q    <= REG2_RST;
            reg3_q    <= REG3_RST;
            wr_stb_q  <= 3'b000;
            wr_err_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            wr_stb_q <= 3'b000;
            if (err_clr) begin
                wr_err_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (!we_s) begin
                        state_q   <= LOW;
                        low_cnt_q <= 3'd1;
                        busy_q    <= 1'b1;
                        h_cs_q    <= cs_n;
                        h_addr_q  <= addr;
                        h_din_q   <= din;
                    end
                end
                LOW: begin
                    h_cs_q   <= cs_n;
                    h_addr_q <= addr;
                    h_din_q  <= din;
                    if (!we_s) begin
                        if (low_cnt_q < CNT_MAX) begin
                            low_cnt_q <= low_cnt_q + 3'd1;
                        end
                    end else if (low_cnt_q >= CNT_MAX) begin
                        state_q   <= COMMIT;
                        low_cnt_q <= 3'd0;
                        // Placed after err_clr so a same-edge set overrides the clear.
                        if (!h_cs_q) begin
                            case (h_addr_q)
                                ADDR_REG1: begin
                                    reg1_q             <= h_din_q;
                                    wr_stb_q[STB_REG1] <= 1'b1;
                                end
                                ADDR_REG2: begin
                                    reg2_q             <= h_din_q;
                                    wr_stb_q[STB_REG2] <= 1'b1;
                                end
                                ADDR_REG3: begin
                                    reg3_q             <= h_din_q;
                                    wr_stb_q[STB_REG3] <= 1'b1;
                                end
                                default: wr_err_q <= 1'b1;
                            endcase
                        end
                    end else begin
                        state_q   <= IDLE;
                        low_cnt_q <= 3'd0;
                        busy_q    <= 1'b0;
                    end
                end
                COMMIT: begin
                    if (!we_s) begin
                        state_q   <= LOW;
                        low_cnt_q <= 3'd1;
                        h_cs_q    <= cs_n;
                        h_addr_q  <= addr;
                        h_din_q   <= din;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    low_cnt_q <= 3'd0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign reg1   = reg1_q;
    assign reg2   = reg2_q;
    assign reg3   = reg3_q;
    assign wr_stb = wr_stb_q;
    assign wr_err = wr_err_q;
    assign busy   = busy_q;

endmodule
